pcie_io_mem_slave: RTL and testbench
====================================

Name: pcie_io_mem_slave

Overview:
- Memory-side target for the PCIe I/O endpoint's request/response interface; consumes its mem request stream and produces its mem response stream.
- Owns a single-port 64-bit wide local SRAM (BAR-mapped register/scratch window).
- Handles single and burst reads, beat-per-request writes, out-of-window faults, and response backpressure through a 2-entry response FIFO.

Parameters:
- MEM_ABITS, 9, word-address width; window = 2^MEM_ABITS x 8 B (default 4 KB of the 8 KB addr space).

Ports:
- i_clk  in  1  system bus clock
- i_rst  in  1  reset
- o_req_mem_ready  out  1  ready to accept request beat
- i_req_mem_valid  in  1  request beat valid
- i_req_mem_64  in  1  0=32-bit, 1=64-bit TLP; informational, no lane conversion
- i_req_mem_write  in  1  0=read, 1=write
- i_req_mem_bytes  in  10  read length in bytes, 0 means 1024
- i_req_mem_addr  in  13  byte address
- i_req_mem_strob  in  8  write byte enables
- i_req_mem_data  in  64  write data
- i_req_mem_last  in  1  last write beat of a sequence
- o_resp_mem_valid  out  1  response beat valid
- o_resp_mem_data  out  64  read data (0 for writes/faults)
- o_resp_mem_fault  out  1  access outside window
- i_resp_mem_ready  in  1  consumer accepts response

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset effects: outputs 0, state IDLE, FIFO empty, in-flight cleared; SRAM contents retained.
  - Applies mid-burst: burst abandoned, no further responses.
- Word index and range check:
  - word index = addr[12:3]
  - in-window iff addr[12:3] < 2^MEM_ABITS
- SRAM: synchronous read, 1-cycle latency; byte-masked write.
- FSM IDLE / WRITE / READ:
  - IDLE:
    - o_req_mem_ready = (fifo_cnt + inflight < 2).
    - Accepted write beat: go to WRITE if !last, else stay.
    - Accepted read: latch word addr and beat count, go to READ.
  - WRITE:
    - ready rule as IDLE.
    - Each accepted beat writes SRAM with strob if in-window; otherwise no write and fault=1.
    - Each beat pushes exactly one response (data 0) into the FIFO.
    - Last beat returns the FSM to IDLE.
    - An accepted read in WRITE is a protocol error: ignored, no response.
  - READ:
    - o_req_mem_ready = 0.
    - beats = ceil((addr[2:0] + bytes_eff)/8), where bytes_eff is 1..1024 (1..129 beats).
    - Issue one SRAM read per cycle while fifo_cnt + inflight < 2.
    - Word address increments by 1 per beat and does not wrap.
    - Beats beyond the window return fault=1, data 0, and no SRAM access.
    - FSM returns to IDLE after the final beat is issued.
- Latency, no backpressure:
  - Write response valid the cycle after accept.
  - First read response valid 2 cycles after accept; following beats 1 per cycle.
- FIFO:
  - 2 entries; output taken from registered head.
  - Push and pop in the same cycle is legal when full or empty.
  - Count never exceeds 2; credit check includes in-flight SRAM reads, so no overflow.
  - o_resp_mem_* stay stable while valid && !ready.
- Ordering: responses are strictly in request order.

Optional Feature:
- PCIE_IO_MEM_ZERO_INIT_EN defined:
  - After reset deassert, FSM enters INIT and writes 0 to one word per cycle, 2^MEM_ABITS cycles.
  - o_req_mem_ready = 0 throughout INIT, then IDLE.
  - Reset during INIT restarts the sweep at word 0.
- Undefined: no INIT state; SRAM holds its prior/undefined contents; ready may assert the first cycle after reset.

Test Plan:
- Write addr 0x010, strob 0xFF, data 0x1122334455667788, last=1; then read addr 0x010, bytes 8 -> write resp fault=0 at +1 cycle; read resp data 0x1122334455667788 at +2 cycles.
- Write strob 0x0F data 0xAAAAAAAABBBBBBBB over prior 0x1122334455667788, then read -> 0x11223344BBBBBBBB.
- Read addr 0x004, bytes 16, i_resp_mem_ready held 0 for 5 cycles -> no FIFO overflow, o_resp_mem_valid stable; 3 beats (words 0,1,2) delivered in order once ready rises.
- Read addr 0xFF8, bytes 16 with MEM_ABITS=9 -> beat 0 data of word 511, fault=0; beat 1 fault=1, data 0. Write to 0x1000 -> fault=1 and SRAM unchanged.
- Read bytes=0 at addr 0 -> exactly 128 response beats; o_req_mem_ready low until the last beat is issued.
- i_rst pulsed mid 8-beat read after 3 responses -> no further responses, FIFO empty, ready=1 next cycle (or after INIT sweep with PCIE_IO_MEM_ZERO_INIT_EN, with subsequent reads returning 0).

Source files
------------

// File: rtl/pcie_io_mem_slave.sv
// pcie_io_mem_slave: BAR-window SRAM target serving the PCIe I/O endpoint mem request/response streams.
// Optional PCIE_IO_MEM_ZERO_INIT_EN: zero-fill the SRAM after every reset before accepting requests.
module pcie_io_mem_slave #(
    parameter int MEM_ABITS = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_req_mem_ready,
    input  logic        i_req_mem_valid,
    input  logic        i_req_mem_64,
    input  logic        i_req_mem_write,
    input  logic [9:0]  i_req_mem_bytes,
    input  logic [12:0] i_req_mem_addr,
    input  logic [7:0]  i_req_mem_strob,
    input  logic [63:0] i_req_mem_data,
    input  logic        i_req_mem_last,
    output logic        o_resp_mem_valid,
    output logic [63:0] o_resp_mem_data,
    output logic        o_resp_mem_fault,
    input  logic        i_resp_mem_ready
);
    localparam logic [10:0] WORDS = 11'(2 ** MEM_ABITS);

`ifdef PCIE_IO_MEM_ZERO_INIT_EN
    typedef enum logic [1:0] {IDLE, WRITE, READ, INIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`endif

    state_t state, state_n;
    logic [63:0] mem [2**MEM_ABITS];
    logic [63:0] mem_q;
    logic [10:0] waddr, waddr_n, req_word, iaddr, bsum;
    logic [7:0] rem, rem_n, beats;
    logic [64:0] e0, e1, e0_n, e1_n, da, db;
    logic [1:0] cnt, cnt_n, n;
    logic p_v, p_fault, pop, acc, pb, req_in, iss, iss_in, init_we;
    logic [MEM_ABITS-1:0] init_addr;
    logic unused;

    assign unused = ^{i_req_mem_64, bsum[2:0]};
    assign req_word = {1'b0, i_req_mem_addr[12:3]};
    assign req_in = req_word < WORDS;
    assign bsum = 11'(i_req_mem_addr[2:0]) + {i_req_mem_bytes == 10'd0, i_req_mem_bytes} + 11'd7;
    assign beats = bsum[10:3];
    assign o_resp_mem_valid = cnt != 2'd0;
    assign o_resp_mem_fault = e0[64];
    assign o_resp_mem_data = e0[63:0];

    always_comb begin
        pop = o_resp_mem_valid && i_resp_mem_ready;
        o_req_mem_ready = !i_rst && (state == IDLE || state == WRITE) && (cnt + 2'(p_v)) < 2'd2;
        acc = i_req_mem_valid && o_req_mem_ready;
        pb = acc && i_req_mem_write;
        iaddr = state == READ ? waddr : req_word;
        // burst beats count this cycle's pop as freed space to sustain one beat per cycle
        iss = state == READ ? (cnt + 2'(p_v)) <= (2'd1 + 2'(pop)) : acc && !i_req_mem_write && state == IDLE;
        iss_in = iaddr < WORDS;
        state_n = state;
        waddr_n = waddr;
        rem_n = rem;
        case (state)
            IDLE: if (acc) begin
                if (i_req_mem_write) state_n = i_req_mem_last ? IDLE : WRITE;
                else begin
                    state_n = beats == 8'd1 ? IDLE : READ;
                    waddr_n = req_word + 11'd1;
                    rem_n = beats - 8'd1;
                end
            end
            WRITE: if (pb && i_req_mem_last) state_n = IDLE;
            READ: if (iss) begin
                waddr_n = waddr + 11'd1;
                rem_n = rem - 8'd1;
                state_n = rem == 8'd1 ? IDLE : READ;
            end
`ifdef PCIE_IO_MEM_ZERO_INIT_EN
            INIT: if (init_addr == '1) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
        da = {p_fault, p_fault ? 64'd0 : mem_q};
        db = {!req_in, 64'd0};
        n = cnt - 2'(pop);
        // older read beat lands ahead of a write response accepted in the same cycle
        e0_n = n != 2'd0 ? (pop ? e1 : e0) : p_v ? da : pb ? db : e0;
        e1_n = n == 2'd2 ? e1 : n == 2'd1 ? (p_v ? da : db) : db;
        cnt_n = n + 2'(p_v) + 2'(pb);
    end

    always_ff @(posedge i_clk) begin
        if (init_we) mem[init_addr] <= '0;
        else if (pb && req_in)
            for (int b = 0; b < 8; b++)
                if (i_req_mem_strob[b]) mem[req_word[MEM_ABITS-1:0]][8*b +: 8] <= i_req_mem_data[8*b +: 8];
        if (iss && iss_in) mem_q <= mem[iaddr[MEM_ABITS-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
`ifdef PCIE_IO_MEM_ZERO_INIT_EN
            state <= INIT;
`else
            state <= IDLE;
`endif
            waddr <= '0;
            rem <= '0;
            p_v <= 1'b0;
            p_fault <= 1'b0;
            cnt <= '0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            state <= state_n;
            waddr <= waddr_n;
            rem <= rem_n;
            p_v <= iss;
            p_fault <= iss && !iss_in;
            cnt <= cnt_n;
            e0 <= e0_n;
            e1 <= e1_n;
        end
    end

`ifdef PCIE_IO_MEM_ZERO_INIT_EN
    assign init_we = state == INIT;
    always_ff @(posedge i_clk) begin
        if (i_rst) init_addr <= '0;
        else if (init_we) init_addr <= init_addr + MEM_ABITS'(1);
    end
`else
    assign init_we = 1'b0;
    assign init_addr = '0;
`endif
endmodule

// File: tb/tb_pcie_io_mem_slave.sv
// tb_pcie_io_mem_slave: directed self-checking bench for pcie_io_mem_slave (MEM_ABITS = 9).
// Responses are captured by a negedge monitor with their cycle numbers; each scenario task checks them.
module tb_pcie_io_mem_slave;
    logic clk = 1'b0, rst = 1'b1;
    logic req_ready, req_valid = 1'b0, req_64 = 1'b1, req_write = 1'b0, req_last = 1'b0;
    logic [9:0] req_bytes = '0;
    logic [12:0] req_addr = '0;
    logic [7:0] req_strob = '0;
    logic [63:0] req_data = '0;
    logic resp_valid, resp_fault, resp_ready = 1'b1;
    logic [63:0] resp_data;
    int errors = 0, checks = 0, cyc = 0;
    logic [64:0] rq[$];
    int rc[$];

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D2 = 64'h0F0F_F0F0_3C3C_C3C3;
    localparam logic [63:0] W = 64'h1122_3344_5566_7788;
    localparam logic [63:0] P = 64'h1122_3344_BBBB_BBBB;
    localparam logic [63:0] X5 = 64'hDEAD_BEEF_CAFE_F00D;
`ifdef PCIE_IO_MEM_ZERO_INIT_EN
    localparam logic [63:0] RET0 = 64'd0;
`else
    localparam logic [63:0] RET0 = D0;
`endif

    pcie_io_mem_slave #(.MEM_ABITS(9)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_req_mem_ready(req_ready), .i_req_mem_valid(req_valid), .i_req_mem_64(req_64),
        .i_req_mem_write(req_write), .i_req_mem_bytes(req_bytes), .i_req_mem_addr(req_addr),
        .i_req_mem_strob(req_strob), .i_req_mem_data(req_data), .i_req_mem_last(req_last),
        .o_resp_mem_valid(resp_valid), .o_resp_mem_data(resp_data), .o_resp_mem_fault(resp_fault),
        .i_resp_mem_ready(resp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk)
        if (!rst && resp_valid && resp_ready) begin
            rq.push_back({resp_fault, resp_data});
            rc.push_back(cyc);
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [12:0] addr, input logic [9:0] bytes,
                        input logic [7:0] strob, input logic [63:0] data, input logic last, output int acc_c);
        int t = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_bytes = bytes;
        req_strob = strob; req_data = data; req_last = last;
        while (!req_ready && t < 1100) begin tick(); t++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", req_ready, t);
        end
        acc_c = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int t = 0;
        while (rq.size() < n && t < 400) begin tick(); t++; end
        if (rq.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_resp: got %0d responses, required %0d", rq.size(), n);
        end
    endtask

    task automatic wait_ready;
        int t = 0;
        while (!req_ready && t < 1100) begin tick(); t++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", req_ready, t);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", resp_valid); end
        checks++; if ({resp_fault, resp_data} !== 65'd0) begin errors++; $display("FAIL reset_resp: got %h required 0", {resp_fault, resp_data}); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", req_ready); end
        rst = 1'b0;
        wait_ready();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        int a0, a1, a2;
        rq.delete(); rc.delete();
        send(1'b1, 13'h000, 10'd8, 8'hFF, D0, 1'b0, a0);
        send(1'b1, 13'h008, 10'd8, 8'hFF, D1, 1'b0, a1);
        send(1'b1, 13'h010, 10'd8, 8'hFF, D2, 1'b1, a2);
        checks++; if (a2 !== a0 + 2) begin errors++; $display("FAIL b2b_accept: last beat at cycle %0d required %0d", a2, a0 + 2); end
        wait_resp(3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (rq[i] !== 65'd0) begin errors++; $display("FAIL b2b_resp%0d: got %h required 0", i, rq[i]); end
            checks++; if (rc[i] !== a0 + 1 + i) begin errors++; $display("FAIL b2b_lat%0d: cycle %0d required %0d", i, rc[i], a0 + 1 + i); end
        end
    endtask

    task automatic test_write_read;
        int aw, ar;
        rq.delete(); rc.delete();
        send(1'b1, 13'h010, 10'd8, 8'hFF, W, 1'b1, aw);
        send(1'b0, 13'h010, 10'd8, 8'h00, 64'd0, 1'b0, ar);
        wait_resp(2);
        checks++; if (rq[0] !== 65'd0) begin errors++; $display("FAIL wr_resp: got %h required 0", rq[0]); end
        checks++; if (rc[0] !== aw + 1) begin errors++; $display("FAIL wr_lat: cycle %0d required %0d", rc[0], aw + 1); end
        checks++; if (rq[1] !== {1'b0, W}) begin errors++; $display("FAIL rd_data: got %h required %h", rq[1], {1'b0, W}); end
        checks++; if (rc[1] !== ar + 2) begin errors++; $display("FAIL rd_lat: cycle %0d required %0d", rc[1], ar + 2); end
    endtask

    task automatic test_partial;
        int a;
        rq.delete(); rc.delete();
        send(1'b1, 13'h010, 10'd8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b1, a);
        send(1'b0, 13'h010, 10'd8, 8'h00, 64'd0, 1'b0, a);
        wait_resp(2);
        checks++; if (rq[0] !== 65'd0) begin errors++; $display("FAIL partial_wr: got %h required 0", rq[0]); end
        checks++; if (rq[1] !== {1'b0, P}) begin errors++; $display("FAIL partial_rd: got %h required %h", rq[1], {1'b0, P}); end
    endtask

    task automatic test_backpressure;
        int a;
        rq.delete(); rc.delete();
        resp_ready = 1'b0;
        send(1'b0, 13'h004, 10'd16, 8'h00, 64'd0, 1'b0, a);
        tick();
        checks++; if ({resp_valid, resp_fault, resp_data} !== {2'b10, D0}) begin errors++; $display("FAIL bp_first: got %h required %h", {resp_valid, resp_fault, resp_data}, {2'b10, D0}); end
        repeat (5) begin
            tick();
            checks++; if ({resp_valid, resp_fault, resp_data} !== {2'b10, D0}) begin errors++; $display("FAIL bp_stable: got %h required %h", {resp_valid, resp_fault, resp_data}, {2'b10, D0}); end
        end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b required 0", req_ready); end
        resp_ready = 1'b1;
        wait_resp(3);
        repeat (5) tick();
        checks++; if (rq.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d required 3", rq.size()); end
        checks++; if (rq[0] !== {1'b0, D0}) begin errors++; $display("FAIL bp_beat0: got %h required %h", rq[0], {1'b0, D0}); end
        checks++; if (rq[1] !== {1'b0, D1}) begin errors++; $display("FAIL bp_beat1: got %h required %h", rq[1], {1'b0, D1}); end
        checks++; if (rq[2] !== {1'b0, P}) begin errors++; $display("FAIL bp_beat2: got %h required %h", rq[2], {1'b0, P}); end
    endtask

    task automatic test_boundary;
        int a;
        rq.delete(); rc.delete();
        send(1'b1, 13'hFF8, 10'd8, 8'hFF, X5, 1'b1, a);
        send(1'b0, 13'hFF8, 10'd16, 8'h00, 64'd0, 1'b0, a);
        wait_resp(3);
        checks++; if (rq[0] !== 65'd0) begin errors++; $display("FAIL edge_wr: got %h required 0", rq[0]); end
        checks++; if (rq[1] !== {1'b0, X5}) begin errors++; $display("FAIL edge_beat0: got %h required %h", rq[1], {1'b0, X5}); end
        checks++; if (rq[2] !== {1'b1, 64'd0}) begin errors++; $display("FAIL edge_beat1: got %h required %h", rq[2], {1'b1, 64'd0}); end
        rq.delete(); rc.delete();
        send(1'b1, 13'h1000, 10'd8, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, a);
        send(1'b0, 13'h000, 10'd8, 8'h00, 64'd0, 1'b0, a);
        wait_resp(2);
        checks++; if (rq[0] !== {1'b1, 64'd0}) begin errors++; $display("FAIL oow_wr: got %h required %h", rq[0], {1'b1, 64'd0}); end
        checks++; if (rq[1] !== {1'b0, D0}) begin errors++; $display("FAIL oow_unchanged: got %h required %h", rq[1], {1'b0, D0}); end
    endtask

    task automatic test_long_read;
        int a, highs = 0, faults = 0;
        rq.delete(); rc.delete();
        send(1'b0, 13'h000, 10'd0, 8'h00, 64'd0, 1'b0, a);
        for (int i = 1; i <= 127; i++) begin
            if (req_ready) highs++;
            tick();
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL long_ready_low: ready high %0d cycles required 0", highs); end
        wait_resp(128);
        repeat (10) tick();
        foreach (rq[i]) if (rq[i][64]) faults++;
        checks++; if (rq.size() !== 128) begin errors++; $display("FAIL long_count: got %0d required 128", rq.size()); end
        checks++; if (faults !== 0) begin errors++; $display("FAIL long_faults: got %0d required 0", faults); end
        checks++; if (rq[0] !== {1'b0, D0}) begin errors++; $display("FAIL long_beat0: got %h required %h", rq[0], {1'b0, D0}); end
        checks++; if (rq[1] !== {1'b0, D1}) begin errors++; $display("FAIL long_beat1: got %h required %h", rq[1], {1'b0, D1}); end
        checks++; if (rc[127] !== a + 129) begin errors++; $display("FAIL long_last_lat: cycle %0d required %0d", rc[127], a + 129); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL long_ready_after: got %b required 1", req_ready); end
    endtask

    task automatic test_reset_mid_burst;
        int a, t = 0, highs = 0;
        rq.delete(); rc.delete();
        send(1'b0, 13'h000, 10'd64, 8'h00, 64'd0, 1'b0, a);
        while (rq.size() < 3 && t < 50) begin tick(); t++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", resp_valid); end
        wait_ready();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b required 1", req_ready); end
        repeat (20) begin
            if (resp_valid) highs++;
            tick();
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL rst_mid_quiet: valid high %0d cycles required 0", highs); end
        checks++; if (rq.size() !== 3) begin errors++; $display("FAIL rst_mid_count: got %0d required 3", rq.size()); end
        checks++; if (rq[2] !== {1'b0, P}) begin errors++; $display("FAIL rst_mid_beat2: got %h required %h", rq[2], {1'b0, P}); end
        rq.delete(); rc.delete();
        send(1'b0, 13'h000, 10'd8, 8'h00, 64'd0, 1'b0, a);
        wait_resp(1);
        checks++; if (rq[0] !== {1'b0, RET0}) begin errors++; $display("FAIL rst_mid_retain: got %h required %h", rq[0], {1'b0, RET0}); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_write_read();
        test_partial();
        test_backpressure();
        test_boundary();
        test_long_read();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
